addr_region_guard: RTL and testbench

Programmable, pipelined address-map checker for the Security-Engine SoC. It holds a runtime table of NrRegions base/length/permission entries, one per crossbar slave (DRAM, ECIES, PUF, ODO, SHA, RSA, TRNG, ECC, AES, DH, ECDSA, …). For each master request it returns the matching region index plus an allow/deny verdict, replacing the fixed compile-time address rules. It sits in front of the AXI crossbar's address decode. It also keeps sticky violation diagnostics for the security monitor.

---
 rtl/addr_region_guard.sv | 245 ++++++++++++++++++++++++
 tb/tb_addr_region_guard.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_region_guard.sv
`default_nettype none
// ============================================================================
// Module   : addr_region_guard
// Purpose  : Programmable address-map checker with two pipeline stages.
//            A runtime table of base/length/permission regions is compared
//            against every request. The response carries the lowest matching
//            region index and an allow/deny verdict. Sticky violation
//            diagnostics are kept for the security monitor.
// Revision : 1.0  initial release
// ============================================================================
module addr_region_guard #(
    parameter  int NR_REGIONS = 20,
    parameter  int ADDR_WIDTH = 64,
    parameter  int ID_WIDTH   = 4,
    localparam int IDX_WIDTH  = $clog2(NR_REGIONS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // table configuration
    input  logic                  cfg_we_i,
    input  logic [IDX_WIDTH-1:0]  cfg_idx_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_len_i,
    input  logic [2:0]            cfg_perm_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_err_o,
    // request channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic                  req_user_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDX_WIDTH-1:0]  rsp_idx_o,
    output logic                  rsp_hit_o,
    output logic                  rsp_allow_o,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    // violation diagnostics
    output logic                  viol_valid_o,
    output logic [ADDR_WIDTH-1:0] viol_addr_o,
    output logic [ID_WIDTH-1:0]   viol_id_o,
    output logic [15:0]           viol_cnt_o,
    input  logic                  viol_clr_i
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Region table; perm bits are {U, W, R}
    logic [ADDR_WIDTH-1:0] r_base [NR_REGIONS];
    logic [ADDR_WIDTH-1:0] r_len  [NR_REGIONS];
    logic [2:0]            r_perm [NR_REGIONS];
    logic [NR_REGIONS-1:0] r_lock;
    logic                  r_cfg_err;

    // Pipeline registers
    logic                  r_s1_valid;
    logic [NR_REGIONS-1:0] r_s1_match;
    logic [NR_REGIONS-1:0] r_s1_pok;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [ID_WIDTH-1:0]   r_s1_id;

    logic                  r_s2_valid;
    logic [IDX_WIDTH-1:0]  r_s2_idx;
    logic                  r_s2_hit;
    logic                  r_s2_allow;
    logic [ID_WIDTH-1:0]   r_s2_id;

    // Violation capture
    logic                  r_viol_valid;
    logic [ADDR_WIDTH-1:0] r_viol_addr;
    logic [ID_WIDTH-1:0]   r_viol_id;
    logic [15:0]           r_viol_cnt;

    logic                  w_cfg_in_range;
    logic                  w_cfg_locked;
    logic                  w_cfg_accept;
    logic [NR_REGIONS-1:0] w_match;
    logic [NR_REGIONS-1:0] w_pok;
    logic                  w_s2_load;
    logic                  w_s1_advance;
    logic                  w_req_ready;
    logic                  w_req_fire;
    logic [IDX_WIDTH-1:0]  w_pe_idx;
    logic                  w_pe_hit;
    logic                  w_pe_allow;
    logic                  w_viol;
    logic                  w_out_en;

    // Decide whether the current configuration write may touch the table
    always_comb begin
        w_cfg_in_range = (32'(cfg_idx_i) < 32'(NR_REGIONS));
        w_cfg_locked   = 1'b0;
        for (int i = 0; i < NR_REGIONS; i++) begin
            if (cfg_idx_i == IDX_WIDTH'(i)) begin
                w_cfg_locked = r_lock[i];
            end
        end
        w_cfg_accept = cfg_we_i & w_cfg_in_range & ~w_cfg_locked;
    end

    // Table storage; locks are set by a locking write and clear only on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_REGIONS; i++) begin
                r_base[i] <= '0;
                r_len[i]  <= '0;
                r_perm[i] <= '0;
            end
            r_lock    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NR_REGIONS; i++) begin
                if (w_cfg_accept && (cfg_idx_i == IDX_WIDTH'(i))) begin
                    r_base[i] <= cfg_base_i;
                    r_len[i]  <= cfg_len_i;
                    r_perm[i] <= cfg_perm_i;
                    if (cfg_lock_i) begin
                        r_lock[i] <= 1'b1;
                    end
                end
            end
            r_cfg_err <= cfg_we_i & ~(w_cfg_in_range & ~w_cfg_locked);
        end
    end

    // Per-region compare; the end address carries one extra bit so a region
    // touching the top of the address space does not wrap to zero
    generate
        for (genvar g = 0; g < NR_REGIONS; g++) begin : g_region
            logic [ADDR_WIDTH:0] w_end;
            logic                w_rw_ok;
            assign w_end      = {1'b0, r_base[g]} + {1'b0, r_len[g]};
            assign w_match[g] = (r_len[g] != '0) &&
                                (req_addr_i >= r_base[g]) &&
                                ({1'b0, req_addr_i} < w_end);
            assign w_rw_ok    = req_we_i ? r_perm[g][1] : r_perm[g][0];
            assign w_pok[g]   = w_rw_ok & (~req_user_i | r_perm[g][2]);
        end
    endgenerate

    // Flow control: both stages move when the output slot is free or draining
    assign w_s2_load    = ~r_s2_valid | rsp_ready_i;
    assign w_s1_advance = w_s2_load;
    assign w_req_ready  = ~r_s1_valid | w_s1_advance;
    assign w_req_fire   = req_valid_i & w_req_ready;

    // Stage 1: capture match/permission vectors for an accepted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
            r_s1_pok   <= '0;
            r_s1_addr  <= '0;
            r_s1_id    <= '0;
        end else if (w_req_ready) begin
            r_s1_valid <= req_valid_i;
            if (w_req_fire) begin
                r_s1_match <= w_match;
                r_s1_pok   <= w_pok;
                r_s1_addr  <= req_addr_i;
                r_s1_id    <= req_id_i;
            end
        end
    end

    // Priority encoder: scanning downward leaves the lowest matching index
    always_comb begin
        w_pe_idx   = '0;
        w_pe_hit   = 1'b0;
        w_pe_allow = 1'b0;
        for (int i = NR_REGIONS - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_pe_idx   = IDX_WIDTH'(i);
                w_pe_hit   = 1'b1;
                w_pe_allow = r_s1_pok[i];
            end
        end
    end

    // Stage 2: response register, held while the consumer stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_hit   <= 1'b0;
            r_s2_allow <= 1'b0;
            r_s2_id    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_idx   <= w_pe_idx;
                r_s2_hit   <= w_pe_hit;
                r_s2_allow <= w_pe_allow;
                r_s2_id    <= r_s1_id;
            end
        end
    end

    assign w_viol = w_s2_load & r_s1_valid & ~w_pe_allow;

    // Violation diagnostics; a violation arriving with a clear restarts the log
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_viol_valid <= 1'b0;
            r_viol_addr  <= '0;
            r_viol_id    <= '0;
            r_viol_cnt   <= '0;
        end else if (w_viol) begin
            if (viol_clr_i) begin
                r_viol_cnt <= 16'd1;
            end else if (r_viol_cnt != c_CNT_MAX) begin
                r_viol_cnt <= r_viol_cnt + 16'd1;
            end
            if (~r_viol_valid | viol_clr_i) begin
                r_viol_valid <= 1'b1;
                r_viol_addr  <= r_s1_addr;
                r_viol_id    <= r_s1_id;
            end
        end else if (viol_clr_i) begin
            r_viol_valid <= 1'b0;
            r_viol_addr  <= '0;
            r_viol_id    <= '0;
            r_viol_cnt   <= '0;
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign w_out_en     = ~rst_i;
    assign cfg_err_o    = w_out_en & r_cfg_err;
    assign req_ready_o  = w_out_en & w_req_ready;
    assign rsp_valid_o  = w_out_en & r_s2_valid;
    assign rsp_idx_o    = w_out_en ? r_s2_idx : '0;
    assign rsp_hit_o    = w_out_en & r_s2_hit;
    assign rsp_allow_o  = w_out_en & r_s2_allow;
    assign rsp_id_o     = w_out_en ? r_s2_id : '0;
    assign viol_valid_o = w_out_en & r_viol_valid;
    assign viol_addr_o  = w_out_en ? r_viol_addr : '0;
    assign viol_id_o    = w_out_en ? r_viol_id : '0;
    assign viol_cnt_o   = w_out_en ? r_viol_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_addr_region_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_region_guard
// Purpose  : Self-checking bench for addr_region_guard: directed vector
//            table plus hand-written multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_addr_region_guard;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic        user;
        logic [3:0]  id;
        logic [4:0]  idx;
        logic        hit;
        logic        allow;
    } vec_t;

    localparam int c_NV = 13;
    localparam int c_NB = 40;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_we_i = 1'b0;
    logic [4:0]  cfg_idx_i = '0;
    logic [63:0] cfg_base_i = '0;
    logic [63:0] cfg_len_i = '0;
    logic [2:0]  cfg_perm_i = '0;
    logic        cfg_lock_i = 1'b0;
    logic        cfg_err_o;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic        req_user_i = 1'b0;
    logic [3:0]  req_id_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [4:0]  rsp_idx_o;
    logic        rsp_hit_o;
    logic        rsp_allow_o;
    logic [3:0]  rsp_id_o;
    logic        viol_valid_o;
    logic [63:0] viol_addr_o;
    logic [3:0]  viol_id_o;
    logic [15:0] viol_cnt_o;
    logic        viol_clr_i = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs [c_NV];

    addr_region_guard dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_perm_i   (cfg_perm_i),
        .cfg_lock_i   (cfg_lock_i),
        .cfg_err_o    (cfg_err_o),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_we_i     (req_we_i),
        .req_user_i   (req_user_i),
        .req_id_i     (req_id_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_idx_o    (rsp_idx_o),
        .rsp_hit_o    (rsp_hit_o),
        .rsp_allow_o  (rsp_allow_o),
        .rsp_id_o     (rsp_id_o),
        .viol_valid_o (viol_valid_o),
        .viol_addr_o  (viol_addr_o),
        .viol_id_o    (viol_id_o),
        .viol_cnt_o   (viol_cnt_o),
        .viol_clr_i   (viol_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic [63:0] a, input logic we, input logic u,
                                input logic [3:0] id, input logic [4:0] idx,
                                input logic hit, input logic allow);
        vec_t v;
        v.addr = a; v.we = we; v.user = u; v.id = id;
        v.idx = idx; v.hit = hit; v.allow = allow;
        return v;
    endfunction

    function automatic logic [11:0] rsp_now();
        return {rsp_valid_o, rsp_idx_o, rsp_hit_o, rsp_allow_o, rsp_id_o};
    endfunction

    function automatic logic [11:0] rsp_exp(input vec_t v);
        return {1'b1, v.idx, v.hit, v.allow, v.id};
    endfunction

    // Table write; err returns cfg_err_o one cycle after the write
    task automatic cfg_wr(input logic [4:0] idx, input logic [63:0] base,
                          input logic [63:0] len, input logic [2:0] perm,
                          input logic lock, output logic err);
        @(negedge clk);
        cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_base_i = base;
        cfg_len_i = len; cfg_perm_i = perm; cfg_lock_i = lock;
        @(posedge clk);
        @(negedge clk);
        cfg_we_i = 1'b0; cfg_lock_i = 1'b0;
        err = cfg_err_o;
    endtask

    // Single request with idle pipeline: checks the two-cycle latency and fields
    task automatic do_req(input string name, input vec_t v);
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = v.addr; req_we_i = v.we;
        req_user_i = v.user; req_id_i = v.id;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        check({name, "_lat1"}, 64'(rsp_valid_o), 64'd0);
        @(negedge clk);
        check(name, 64'(rsp_now()), 64'(rsp_exp(v)));
    endtask

    initial begin
        logic        err;
        vec_t        v;
        vec_t        e;
        vec_t        exp_q[$];
        logic [11:0] held;
        logic        stall_prev;
        logic        stale;
        int          sent;
        int          got;
        int          cyc;

        // Reset state
        @(negedge clk);
        check("reset_outs",
              {req_ready_o, rsp_valid_o, cfg_err_o, viol_valid_o, viol_cnt_o},
              '0);
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready_o), 64'd1);

        // Region table for the vector run
        cfg_wr(5'd8, 64'h4500_0000, 64'h1_0000, 3'b011, 1'b0, err);
        check("cfg8_err", 64'(err), 64'd0);
        cfg_wr(5'd3, 64'h1000_0000, 64'h1000, 3'b001, 1'b0, err);
        cfg_wr(5'd5, 64'h1000_0800, 64'h1000, 3'b111, 1'b0, err);
        cfg_wr(5'd12, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b111, 1'b0, err);
        cfg_wr(5'd0, 64'h2000, 64'h100, 3'b101, 1'b0, err);

        vecs[0]  = mk(64'h4500_0010,     0, 0, 4'd1,  5'd8,  1, 1);
        vecs[1]  = mk(64'h4500_0020,     1, 1, 4'd2,  5'd8,  1, 0);
        vecs[2]  = mk(64'h9000_0000_0000,0, 0, 4'd3,  5'd0,  0, 0);
        vecs[3]  = mk(64'h1000_0900,     0, 0, 4'd4,  5'd3,  1, 1);
        vecs[4]  = mk(64'h1000_0900,     1, 0, 4'd5,  5'd3,  1, 0);
        vecs[5]  = mk(64'h1000_1000,     1, 0, 4'd6,  5'd5,  1, 1);
        vecs[6]  = mk(64'h1000_17FF,     1, 1, 4'd7,  5'd5,  1, 1);
        vecs[7]  = mk(64'h1000_1800,     0, 0, 4'd8,  5'd0,  0, 0);
        vecs[8]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 4'd9, 5'd12, 1, 1);
        vecs[9]  = mk(64'h0,             0, 0, 4'd10, 5'd0,  0, 0);
        vecs[10] = mk(64'h2000,          0, 1, 4'd11, 5'd0,  1, 1);
        vecs[11] = mk(64'h2000,          1, 1, 4'd12, 5'd0,  1, 0);
        vecs[12] = mk(64'h1FFF,          0, 0, 4'd13, 5'd0,  0, 0);

        for (int i = 0; i < c_NV; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Seven denials in the table; first one is the user write at 0x4500_0020
        check("viol_valid", 64'(viol_valid_o), 64'd1);
        check("viol_addr", viol_addr_o, 64'h4500_0020);
        check("viol_id", 64'(viol_id_o), 64'd2);
        check("viol_cnt", 64'(viol_cnt_o), 64'd7);

        // Lock entry 3, then a rewrite and an out-of-range write are rejected
        cfg_wr(5'd3, 64'h1000_0000, 64'h1000, 3'b001, 1'b1, err);
        check("lock_wr_err", 64'(err), 64'd0);
        cfg_wr(5'd3, 64'h3000_0000, 64'h1000, 3'b111, 1'b0, err);
        check("locked_wr_err", 64'(err), 64'd1);
        @(negedge clk);
        check("err_one_cycle", 64'(cfg_err_o), 64'd0);
        do_req("lock_old", mk(64'h1000_0010, 0, 0, 4'd4, 5'd3, 1, 1));
        do_req("lock_new", mk(64'h3000_0000, 0, 0, 4'd5, 5'd0, 0, 0));
        cfg_wr(5'd20, 64'h6000_0000, 64'h1000, 3'b111, 1'b0, err);
        check("range_wr_err", 64'(err), 64'd1);

        // Write and request in the same cycle: the request sees the old entry
        @(negedge clk);
        cfg_we_i = 1'b1; cfg_idx_i = 5'd7; cfg_base_i = 64'h5000_0000;
        cfg_len_i = 64'h100; cfg_perm_i = 3'b111;
        req_valid_i = 1'b1; req_addr_i = 64'h5000_0010; req_we_i = 1'b0;
        req_user_i = 1'b0; req_id_i = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cfg_we_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        check("same_cyc_old", 64'(rsp_now()), 64'({1'b1, 5'd0, 1'b0, 1'b0, 4'd3}));
        do_req("same_cyc_new", mk(64'h5000_0010, 0, 0, 4'd6, 5'd7, 1, 1));

        // Clear coinciding with a violation: the new violation is kept
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 64'h7777_0000; req_id_i = 4'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0; viol_clr_i = 1'b1;
        @(negedge clk);
        viol_clr_i = 1'b0;
        check("clr_viol_cnt", 64'(viol_cnt_o), 64'd1);
        check("clr_viol_addr", viol_addr_o, 64'h7777_0000);
        check("clr_viol_id", 64'(viol_id_o), 64'd9);
        check("clr_viol_valid", 64'(viol_valid_o), 64'd1);
        viol_clr_i = 1'b1;
        @(negedge clk);
        viol_clr_i = 1'b0;
        check("clr_alone", {viol_valid_o, viol_cnt_o, viol_addr_o[15:0]}, 64'd0);

        // Back-to-back traffic with random response stalls
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while (got < c_NB && cyc < 3000) begin
            @(negedge clk);
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            if (sent < c_NB) begin
                v = vecs[sent % c_NV];
                req_valid_i = 1'b1; req_addr_i = v.addr; req_we_i = v.we;
                req_user_i = v.user; req_id_i = sent[3:0];
            end else begin
                req_valid_i = 1'b0;
            end
            #1;
            if (stall_prev) check("stall_hold", 64'(rsp_now()), 64'(held));
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("b2b%0d", got), 64'(rsp_now()), 64'(rsp_exp(e)));
                end
                got++;
            end
            stall_prev = rsp_valid_o && !rsp_ready_i;
            held = rsp_now();
            if (req_valid_i && req_ready_o) begin
                v.id = sent[3:0];
                exp_q.push_back(v);
                sent++;
            end
            cyc++;
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        check("b2b_count", 64'(got), 64'(c_NB));
        check("b2b_left", 64'(exp_q.size()), 64'd0);

        // Counter saturation after more than 65535 denials
        @(negedge clk);
        viol_clr_i = 1'b1;
        @(negedge clk);
        viol_clr_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 64'h0; req_we_i = 1'b0;
        req_user_i = 1'b0; req_id_i = 4'd1;
        repeat (65540) @(negedge clk);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("viol_sat", 64'(viol_cnt_o), 64'hFFFF);

        // Reset with requests in flight: nothing stale comes out afterwards
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 64'h4500_0010; req_id_i = 4'd7;
        repeat (2) @(negedge clk);
        req_valid_i = 1'b0; rst_i = 1'b1;
        #1;
        check("in_reset_outs",
              {req_ready_o, rsp_valid_o, cfg_err_o, viol_valid_o, viol_cnt_o},
              '0);
        @(negedge clk);
        rst_i = 1'b0;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stale = stale | rsp_valid_o;
        end
        check("no_stale_rsp", 64'(stale), 64'd0);
        check("cnt_after_reset", 64'(viol_cnt_o), 64'd0);
        do_req("table_cleared", mk(64'h4500_0010, 0, 0, 4'd2, 5'd0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
